mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (I) and data load/store (D).
- Accepts one request at a time from either requester and issues it to memory with a valid/ready handshake.
- Routes the response back to the requester that owns the transaction.
- Provides data-priority arbitration with an anti-starvation guard, plus a response timeout that returns an error instead of hanging the pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting; after that, I gets the next grant.
- TIMEOUT_CYCLES, 64, cycles in WAIT without mem_resp_valid before an error response is forced.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  in  1  fetch request.
- ireq_addr  in  ADDR_W  fetch address.
- ireq_ready  out  1  fetch request accepted this cycle.
- iresp_valid  out  1  one-cycle fetch response pulse.
- iresp_data  out  DATA_W  fetched word.
- iresp_err  out  1  fetch timed out.
- dreq_valid  in  1  data request.
- dreq_we  in  1  1 = store.
- dreq_addr  in  ADDR_W  data address.
- dreq_wdata  in  DATA_W  store data.
- dreq_wstrb  in  DATA_W/8  byte enables.
- dreq_ready  out  1  data request accepted this cycle.
- dresp_valid  out  1  one-cycle data response pulse.
- dresp_rdata  out  DATA_W  load data; 0 for stores.
- dresp_err  out  1  data access timed out.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  store.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  store data.
- mem_wstrb  out  DATA_W/8  byte enables; all zeros for reads.
- mem_resp_valid  in  1  memory response (read data or write ack).
- mem_resp_data  in  DATA_W  read data.

Behaviour:
- Reset: async and immediate. state=IDLE, streak=0, timer=0, owner=I. All outputs 0, including mem_* buses and resp data.
- States: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - ireq_ready and dreq_ready are combinational and asserted only in IDLE, to the grant winner only. They are never both high.
  - Grant rule: D wins if dreq_valid, unless ireq_valid && streak==MAX_D_STREAK, in which case I wins. Otherwise I wins if ireq_valid.
  - On handshake: latch owner, we, addr, wdata, wstrb (I: we=0, wstrb=0). Go to ISSUE.
  - Latency: accept at cycle T, mem_req_valid high from T+1.
- Streak counter:
  - D grant while ireq_valid: streak+1, saturating at MAX_D_STREAK.
  - I grant, or D grant with ireq_valid low: streak=0.
- ISSUE:
  - mem_req_valid=1; mem_* fields are registered and stable until handshake.
  - mem_req_valid && mem_req_ready -> WAIT, timer=0. mem_req_valid drops the next cycle.
  - No timeout in ISSUE.
- WAIT:
  - timer increments each cycle.
  - On mem_resp_valid: next cycle pulse owner's resp_valid with data = mem_resp_data (stores: rdata=0) and err=0; state -> IDLE.
  - Response cycle overlaps IDLE, so a new request may be accepted in the same cycle the previous response pulses.
  - If timer reaches TIMEOUT_CYCLES-1 with no response: next cycle pulse owner's resp_valid with err=1 and data 0; state -> IDLE.
  - mem_resp_valid and timeout in the same cycle: response wins, err=0.
- mem_resp_valid outside WAIT (late response after timeout, or spurious): ignored, no output pulse.
- resp data/err hold their last value when resp_valid is low; err clears on the next normal response to that requester.
- Exactly one response per accepted request. At most one transaction outstanding.
- Reset mid-transaction: transaction is dropped, no response is produced, mem_req_valid drops immediately.

Test Plan:
- I only: ireq addr 0x100, memory ready immediately, mem_resp_valid 3 cycles later with data 0xDEADBEEF -> ireq_ready at T, mem_req_valid T+1 with mem_addr 0x100 and we=0, iresp_valid one cycle after the resp with data 0xDEADBEEF and err=0.
- D store: addr 0x2000, wdata 0x12345678, wstrb 0x3 -> mem_we=1, mem_wstrb=0x3, dresp_valid one cycle after the ack with rdata=0.
- Contention: I and D both requesting continuously with 1-cycle memory, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; never both readys high.
- Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and all mem_* fields stable for those cycles; no timeout fires.
- Timeout: D load, no mem_resp_valid for TIMEOUT_CYCLES=64 -> dresp_valid with err=1 and rdata=0; a late mem_resp_valid after that produces no pulse; the next I request completes normally.
- Reset asserted in WAIT -> outputs 0 immediately; no resp pulse after release; next request works.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D):
// data-priority grants with a starvation guard, one outstanding transaction, response timeout.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ireq_valid,
    input  logic [ADDR_W-1:0]     ireq_addr,
    output logic                  ireq_ready,
    output logic                  iresp_valid,
    output logic [DATA_W-1:0]     iresp_data,
    output logic                  iresp_err,

    input  logic                  dreq_valid,
    input  logic                  dreq_we,
    input  logic [ADDR_W-1:0]     dreq_addr,
    input  logic [DATA_W-1:0]     dreq_wdata,
    input  logic [DATA_W/8-1:0]   dreq_wstrb,
    output logic                  dreq_ready,
    output logic                  dresp_valid,
    output logic [DATA_W-1:0]     dresp_rdata,
    output logic                  dresp_err,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned STRK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam int unsigned TMR_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e              state_q,         state_d;
    logic                owner_q,         owner_d;
    logic                we_q,            we_d;
    logic [ADDR_W-1:0]   addr_q,          addr_d;
    logic [DATA_W-1:0]   wdata_q,         wdata_d;
    logic [STRB_W-1:0]   wstrb_q,         wstrb_d;
    logic [STRK_W-1:0]   streak_q,        streak_d;
    logic [TMR_W-1:0]    timer_q,         timer_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                iresp_valid_q,   iresp_valid_d;
    logic [DATA_W-1:0]   iresp_data_q,    iresp_data_d;
    logic                iresp_err_q,     iresp_err_d;
    logic                dresp_valid_q,   dresp_valid_d;
    logic [DATA_W-1:0]   dresp_rdata_q,   dresp_rdata_d;
    logic                dresp_err_q,     dresp_err_d;

    logic                grant_i_c;
    logic                grant_d_c;
    logic                streak_full_c;
    logic                rsp_fire_c;
    logic                rsp_err_c;
    logic [DATA_W-1:0]   rsp_data_c;

    // Grant: D by default, I once D has won MAX_D_STREAK times in a row over a waiting I.
    always_comb begin
        grant_i_c     = 1'b0;
        grant_d_c     = 1'b0;
        streak_full_c = (streak_q == STRK_W'(MAX_D_STREAK));
        if (state_q == S_IDLE) begin
            if (dreq_valid && !(ireq_valid && streak_full_c)) begin
                grant_d_c = 1'b1;
            end else if (ireq_valid) begin
                grant_i_c = 1'b1;
            end
        end
    end

    assign ireq_ready = grant_i_c;
    assign dreq_ready = grant_d_c;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        streak_d        = streak_q;
        timer_d         = timer_q;
        mem_req_valid_d = mem_req_valid_q;
        iresp_valid_d   = 1'b0;
        iresp_data_d    = iresp_data_q;
        iresp_err_d     = iresp_err_q;
        dresp_valid_d   = 1'b0;
        dresp_rdata_d   = dresp_rdata_q;
        dresp_err_d     = dresp_err_q;
        rsp_fire_c      = 1'b0;
        rsp_err_c       = 1'b0;
        rsp_data_c      = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_i_c) begin
                    owner_d         = OWN_I;
                    we_d            = 1'b0;
                    addr_d          = ireq_addr;
                    wdata_d         = '0;
                    wstrb_d         = '0;
                    streak_d        = '0;
                    mem_req_valid_d = 1'b1;
                    state_d         = S_ISSUE;
                end else if (grant_d_c) begin
                    owner_d         = OWN_D;
                    we_d            = dreq_we;
                    addr_d          = dreq_addr;
                    wdata_d         = dreq_wdata;
                    wstrb_d         = dreq_we ? dreq_wstrb : '0;
                    mem_req_valid_d = 1'b1;
                    state_d         = S_ISSUE;
                    if (!ireq_valid) begin
                        streak_d = '0;
                    end else if (!streak_full_c) begin
                        streak_d = streak_q + STRK_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    timer_d         = '0;
                    state_d         = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response arriving on the timeout cycle still counts as a normal response.
                if (mem_resp_valid) begin
                    rsp_fire_c = 1'b1;
                    rsp_data_c = we_q ? '0 : mem_resp_data;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_fire_c = 1'b1;
                    rsp_err_c  = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                if (rsp_fire_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d         = S_IDLE;
                mem_req_valid_d = 1'b0;
            end
        endcase

        // Route the completion to whichever requester owns the transaction.
        if (rsp_fire_c) begin
            if (owner_q == OWN_D) begin
                dresp_valid_d = 1'b1;
                dresp_rdata_d = rsp_data_c;
                dresp_err_d   = rsp_err_c;
            end else begin
                iresp_valid_d = 1'b1;
                iresp_data_d  = rsp_data_c;
                iresp_err_d   = rsp_err_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            owner_q         <= OWN_I;
            we_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wstrb_q         <= '0;
            streak_q        <= '0;
            timer_q         <= '0;
            mem_req_valid_q <= 1'b0;
            iresp_valid_q   <= 1'b0;
            iresp_data_q    <= '0;
            iresp_err_q     <= 1'b0;
            dresp_valid_q   <= 1'b0;
            dresp_rdata_q   <= '0;
            dresp_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            streak_q        <= streak_d;
            timer_q         <= timer_d;
            mem_req_valid_q <= mem_req_valid_d;
            iresp_valid_q   <= iresp_valid_d;
            iresp_data_q    <= iresp_data_d;
            iresp_err_q     <= iresp_err_d;
            dresp_valid_q   <= dresp_valid_d;
            dresp_rdata_q   <= dresp_rdata_d;
            dresp_err_q     <= dresp_err_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign iresp_valid   = iresp_valid_q;
    assign iresp_data    = iresp_data_q;
    assign iresp_err     = iresp_err_q;
    assign dresp_valid   = dresp_valid_q;
    assign dresp_rdata   = dresp_rdata_q;
    assign dresp_err     = dresp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int          MAXS = 4;
    localparam int          TMO  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          ireq_valid, ireq_ready, iresp_valid, iresp_err;
    logic [AW-1:0] ireq_addr;
    logic [DW-1:0] iresp_data;
    logic          dreq_valid, dreq_we, dreq_ready, dresp_valid, dresp_err;
    logic [AW-1:0] dreq_addr;
    logic [DW-1:0] dreq_wdata, dresp_rdata;
    logic [SW-1:0] dreq_wstrb;
    logic          mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_resp_data;
    logic [SW-1:0] mem_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data), .iresp_err(iresp_err),
        .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
        .dreq_wdata(dreq_wdata), .dreq_wstrb(dreq_wstrb), .dreq_ready(dreq_ready),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .dresp_err(dresp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction plus per-requester response registers.
    bit          m_busy, m_issued, m_owner_d, m_we;
    int          m_timer, m_streak, lat;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    bit          e_ivalid, e_ierr, e_dvalid, e_derr;
    logic [31:0] e_idata, e_ddata;

    // Memory behaviour knobs
    int          rdy_pct = 100, lat_min = 0, lat_max = 0, never_pct = 0, spur_pct = 0;
    bit          fix_data = 1'b0;
    logic [31:0] fixed_data = '0;

    function automatic void model_reset();
        m_busy = 0; m_issued = 0; m_owner_d = 0; m_we = 0;
        m_timer = 0; m_streak = 0; lat = 0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0;
        e_ivalid = 0; e_ierr = 0; e_dvalid = 0; e_derr = 0;
        e_idata = '0; e_ddata = '0;
    endfunction

    function automatic int model_grant();
        if (m_busy) return 0;
        if (dreq_valid && !(ireq_valid && m_streak >= MAXS)) return 2;
        if (ireq_valid) return 1;
        return 0;
    endfunction

    function automatic int pick_lat();
        if (int'($urandom_range(99)) < never_pct) return 1000;
        return int'($urandom_range(lat_max, lat_min));
    endfunction

    function automatic void respond(input logic [31:0] data, input bit err);
        if (m_owner_d) begin e_dvalid = 1; e_ddata = data; e_derr = err; end
        else           begin e_ivalid = 1; e_idata = data; e_ierr = err; end
        m_busy = 0;
    endfunction

    function automatic void model_edge(input int g);
        e_ivalid = 0;
        e_dvalid = 0;
        if (g == 1) begin
            m_busy = 1; m_issued = 0; m_owner_d = 0; m_we = 0;
            m_addr = ireq_addr; m_wdata = '0; m_wstrb = '0; m_streak = 0;
        end else if (g == 2) begin
            m_busy = 1; m_issued = 0; m_owner_d = 1; m_we = dreq_we;
            m_addr = dreq_addr; m_wdata = dreq_wdata;
            m_wstrb = dreq_we ? dreq_wstrb : 4'h0;
            m_streak = ireq_valid ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
        end else if (m_busy && !m_issued) begin
            if (mem_req_ready) begin m_issued = 1; m_timer = 0; lat = pick_lat(); end
        end else if (m_busy) begin
            if (mem_resp_valid)          respond(m_we ? 32'h0 : mem_resp_data, 1'b0);
            else if (m_timer == TMO - 1) respond(32'h0, 1'b1);
            else                         m_timer++;
        end
    endfunction

    task automatic drive_mem();
        mem_req_ready  = (int'($urandom_range(99)) < rdy_pct);
        mem_resp_data  = fix_data ? fixed_data : $urandom();
        mem_resp_valid = 1'b0;
        if (m_busy && m_issued) begin
            if (lat == 0) mem_resp_valid = 1'b1;
            else          lat--;
        end else if (int'($urandom_range(99)) < spur_pct) begin
            mem_resp_valid = 1'b1;
        end
    endtask

    task automatic check_outputs();
        bit exp_mv;
        exp_mv = m_busy && !m_issued;
        check("mem_req_valid", 64'(mem_req_valid), 64'(exp_mv));
        if (exp_mv) begin
            check("mem_we",    64'(mem_we),    64'(m_we));
            check("mem_addr",  64'(mem_addr),  64'(m_addr));
            check("mem_wstrb", 64'(mem_wstrb), 64'(m_wstrb));
            if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        check("iresp_valid", 64'(iresp_valid), 64'(e_ivalid));
        check("iresp_data",  64'(iresp_data),  64'(e_idata));
        check("iresp_err",   64'(iresp_err),   64'(e_ierr));
        check("dresp_valid", 64'(dresp_valid), 64'(e_dvalid));
        check("dresp_rdata", 64'(dresp_rdata), 64'(e_ddata));
        check("dresp_err",   64'(dresp_err),   64'(e_derr));
    endtask

    // One clock: settle inputs, check readys, clock edge, update model, check registered outputs.
    task automatic cycle();
        int g;
        drive_mem();
        #1;
        g = model_grant();
        check("ireq_ready", 64'(ireq_ready), 64'(g == 1));
        check("dreq_ready", 64'(dreq_ready), 64'(g == 2));
        check("both_ready", 64'(ireq_ready & dreq_ready), 64'(0));
        @(posedge clk);
        model_edge(g);
        #1;
        check_outputs();
    endtask

    task automatic idle_reqs();
        ireq_valid = 0; dreq_valid = 0;
    endtask

    task automatic run_until_resp(input int max_cyc, output int n, output bit seen);
        seen = 0;
        n = 0;
        while (!seen && n < max_cyc) begin
            cycle();
            n++;
            if (iresp_valid || dresp_valid) seen = 1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'(0));
        check({tag, "_mem_addr"},      64'(mem_addr),      64'(0));
        check({tag, "_mem_wdata"},     64'(mem_wdata),     64'(0));
        check({tag, "_mem_wstrb_we"},  64'({mem_wstrb, mem_we}), 64'(0));
        check({tag, "_iresp"}, 64'({iresp_valid, iresp_err}), 64'(0));
        check({tag, "_idata"}, 64'(iresp_data), 64'(0));
        check({tag, "_dresp"}, 64'({dresp_valid, dresp_err}), 64'(0));
        check({tag, "_ddata"}, 64'(dresp_rdata), 64'(0));
        check({tag, "_readys"}, 64'({ireq_ready, dreq_ready}), 64'(0));
    endtask

    initial begin
        int  n;
        bit  seen;
        int  grants[$];
        int  exp_grants[10];

        reset = 1'b1;
        ireq_valid = 0; ireq_addr = '0;
        dreq_valid = 0; dreq_we = 0; dreq_addr = '0; dreq_wdata = '0; dreq_wstrb = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // I-only fetch with a fixed read value
        rdy_pct = 100; lat_min = 2; lat_max = 2; never_pct = 0; spur_pct = 0;
        fix_data = 1; fixed_data = 32'hDEADBEEF;
        ireq_valid = 1; ireq_addr = 32'h100;
        cycle();
        idle_reqs();
        check("i_only_mem_valid", 64'(mem_req_valid), 64'(1));
        check("i_only_mem_addr",  64'(mem_addr),      64'(32'h100));
        check("i_only_mem_we",    64'(mem_we),        64'(0));
        run_until_resp(20, n, seen);
        check("i_only_seen", 64'(seen), 64'(1));
        check("i_only_lat",  64'(n),    64'(4));
        check("i_only_data", 64'(iresp_data), 64'(32'hDEADBEEF));
        check("i_only_err",  64'(iresp_err),  64'(0));
        fix_data = 0;

        // D store: rdata must come back as zero
        lat_min = 1; lat_max = 1;
        dreq_valid = 1; dreq_we = 1; dreq_addr = 32'h2000; dreq_wdata = 32'h12345678; dreq_wstrb = 4'h3;
        cycle();
        idle_reqs();
        check("st_mem_we",    64'(mem_we),    64'(1));
        check("st_mem_wstrb", 64'(mem_wstrb), 64'(4'h3));
        check("st_mem_wdata", 64'(mem_wdata), 64'(32'h12345678));
        run_until_resp(20, n, seen);
        check("st_seen",  64'(seen), 64'(1));
        check("st_rdata", 64'(dresp_rdata), 64'(0));
        check("st_err",   64'(dresp_err),   64'(0));

        // Contention: both requesters always valid, one-cycle memory
        lat_min = 0; lat_max = 0;
        exp_grants = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        ireq_valid = 1; dreq_valid = 1; dreq_we = 0;
        for (int c = 0; c < 100 && grants.size() < 10; c++) begin
            ireq_addr = $urandom(); dreq_addr = $urandom(); dreq_wdata = $urandom(); dreq_wstrb = 4'($urandom());
            drive_mem();
            #1;
            if (dreq_ready)      grants.push_back(2);
            else if (ireq_ready) grants.push_back(1);
            @(posedge clk);
            model_edge(model_grant());
            #1;
            check_outputs();
        end
        check("cont_count", 64'(grants.size()), 64'(10));
        for (int k = 0; k < grants.size() && k < 10; k++) check("cont_order", 64'(grants[k]), 64'(exp_grants[k]));
        idle_reqs();
        run_until_resp(20, n, seen);

        // Backpressure: memory not ready for 5 cycles, request must hold
        ireq_valid = 1; ireq_addr = 32'hABCD_0040;
        cycle();
        idle_reqs();
        rdy_pct = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bp_valid", 64'(mem_req_valid), 64'(1));
            check("bp_addr",  64'(mem_addr),      64'(32'hABCD_0040));
        end
        rdy_pct = 100; lat_min = 1; lat_max = 3;
        run_until_resp(20, n, seen);
        check("bp_seen", 64'(seen), 64'(1));
        check("bp_err",  64'(iresp_err), 64'(0));

        // Timeout on a D load, then late responses ignored, then a normal fetch
        never_pct = 100;
        dreq_valid = 1; dreq_we = 0; dreq_addr = 32'h3000; dreq_wstrb = 4'hF;
        cycle();
        idle_reqs();
        run_until_resp(TMO + 20, n, seen);
        check("to_seen",  64'(seen), 64'(1));
        check("to_lat",   64'(n),    64'(TMO + 1));
        check("to_err",   64'(dresp_err),   64'(1));
        check("to_rdata", 64'(dresp_rdata), 64'(0));
        never_pct = 0; spur_pct = 100;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("late_no_pulse", 64'({iresp_valid, dresp_valid}), 64'(0));
        end
        spur_pct = 0;
        ireq_valid = 1; ireq_addr = 32'h200;
        cycle();
        idle_reqs();
        run_until_resp(20, n, seen);
        check("post_to_seen", 64'(seen), 64'(1));
        check("post_to_ierr", 64'(iresp_err), 64'(0));
        check("post_to_derr_hold", 64'(dresp_err), 64'(1));

        // Reset while waiting for a response
        never_pct = 100;
        ireq_valid = 1; ireq_addr = 32'h300;
        cycle();
        idle_reqs();
        repeat (3) cycle();
        check("rst_in_wait", 64'(m_busy && m_issued), 64'(1));
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        never_pct = 0;
        repeat (4) begin
            cycle();
            check("rst_no_pulse", 64'({iresp_valid, dresp_valid}), 64'(0));
        end
        dreq_valid = 1; dreq_we = 0; dreq_addr = 32'h400;
        cycle();
        idle_reqs();
        run_until_resp(20, n, seen);
        check("rst_next_seen", 64'(seen), 64'(1));

        // Randomized traffic
        rdy_pct = 60; lat_min = 0; lat_max = 5; never_pct = 2; spur_pct = 10;
        for (int c = 0; c < 4000; c++) begin
            ireq_valid = ($urandom_range(3) != 0);
            ireq_addr  = $urandom();
            dreq_valid = ($urandom_range(2) != 0);
            dreq_we    = 1'($urandom());
            dreq_addr  = $urandom();
            dreq_wdata = $urandom();
            dreq_wstrb = 4'($urandom());
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
